// File: rtl/cselector_pkg.sv
// Shared types and helpers for the clocked conditional-fork selector family.
// The state enum is also exported on the top-level debug port.
package cselector_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DELAY = 2'd1,
        ST_WAIT  = 2'd2
    } state_e;

    localparam int JOIN_MODE_ANY = 0;
    localparam int JOIN_MODE_ALL = 1;

    // A zero delay still needs a one-bit counter.
    function automatic int cnt_width(input int delay);
        if (delay < 1) return 1;
        return $clog2(delay + 1);
    endfunction

endpackage

// File: rtl/sync_delay_counter.sv
// Loadable saturating down-counter. done_o marks the last counting cycle,
// i.e. the cycle whose closing edge brings the count to zero.
module sync_delay_counter #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    output logic         done_o
);

    logic [W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = load_val_i;
        end else if (count_q != '0) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign done_o = (count_q <= W'(1));

endmodule

// File: rtl/cselector_n_sync.sv
// N-way clocked conditional fork: accept a drive token, wait DRIVE_DELAY cycles,
// pulse the selected channels, then join on their frees before freeing upstream.
module cselector_n_sync
    import cselector_pkg::*;
#(
    parameter int N           = 6,
    parameter int DRIVE_DELAY = 8,
    parameter int JOIN_ALL    = 1
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         i_drive,
    input  logic [N-1:0] i_valid,
    output logic         o_fire,
    output logic [N-1:0] o_driveNext,
    input  logic [N-1:0] i_freeNext,
    output logic         o_free,
    output logic         o_busy,
    output logic         o_err,
    output state_e       o_state
);

    localparam int           CW       = cnt_width(DRIVE_DELAY);
    localparam logic [CW-1:0] LOAD_VAL = CW'(DRIVE_DELAY);
    localparam bit           WAIT_ALL = (JOIN_ALL == JOIN_MODE_ALL);

    state_e       state_q;
    logic [N-1:0] mask_q, pending_q;
    logic         fire_q, free_q, busy_q, err_q;
    logic [N-1:0] drive_q;

    logic         cnt_load, cnt_done, join_done;
    logic [N-1:0] hit, pending_left;

    assign cnt_load = (state_q == ST_IDLE) && i_drive;

    sync_delay_counter #(.W(CW)) u_delay (
        .clk       (clk),
        .rstn      (rstn),
        .load_i    (cnt_load),
        .load_val_i(LOAD_VAL),
        .done_o    (cnt_done)
    );

    // Only frees from selected channels count; repeats clear nothing new.
    assign hit          = i_freeNext & mask_q;
    assign pending_left = pending_q & ~hit;
    assign join_done    = (mask_q == '0) ||
                          (WAIT_ALL ? (pending_left == '0) : (hit != '0));

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= ST_IDLE;
            mask_q    <= '0;
            pending_q <= '0;
            fire_q    <= 1'b0;
            drive_q   <= '0;
            free_q    <= 1'b0;
            busy_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            fire_q  <= 1'b0;
            drive_q <= '0;
            free_q  <= 1'b0;
            err_q   <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (i_drive) begin
                        mask_q    <= i_valid;
                        pending_q <= i_valid;
                        fire_q    <= 1'b1;
                        busy_q    <= 1'b1;
                        if (DRIVE_DELAY == 0) begin
                            drive_q <= i_valid;
                            state_q <= ST_WAIT;
                        end else begin
                            state_q <= ST_DELAY;
                        end
                    end
                end
                ST_DELAY: begin
                    err_q <= i_drive;
                    if (cnt_done) begin
                        drive_q <= mask_q;
                        state_q <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    // A drive arriving with completion is still dropped.
                    err_q     <= i_drive;
                    pending_q <= pending_left;
                    if (join_done) begin
                        free_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign o_fire      = fire_q;
    assign o_driveNext = drive_q;
    assign o_free      = free_q;
    assign o_busy      = busy_q;
    assign o_err       = err_q;
    assign o_state     = state_q;

endmodule

// File: tb/tb_cselector_n_sync.sv
// Bench for cselector_n_sync: three configurations share one stimulus stream and
// are checked every cycle against a timestamp-based transaction model.
module tb_cselector_n_sync;
    import cselector_pkg::*;

    localparam int N  = 6;
    localparam int NI = 3;

    logic         clk = 1'b0;
    logic         rstn = 1'b0;
    logic         drive = 1'b0;
    logic [N-1:0] valid = '0;
    logic [N-1:0] free = '0;

    logic [NI-1:0] fire_o, free_o, busy_o, err_o;
    logic [N-1:0]  drv_o [NI];
    state_e        st_o [NI];

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    // model configuration and state, one slot per instance
    int           m_delay [NI] = '{8, 8, 0};
    bit           m_all   [NI] = '{1'b1, 1'b0, 1'b1};
    bit           act     [NI];
    int           acc     [NI];
    logic [N-1:0] m_mask  [NI];
    logic [N-1:0] m_pend  [NI];
    bit           e_fire  [NI];
    bit           e_free  [NI];
    bit           e_busy  [NI];
    bit           e_err   [NI];
    logic [N-1:0] e_drv   [NI];

    always #5 clk = ~clk;

    cselector_n_sync #(.N(N), .DRIVE_DELAY(8), .JOIN_ALL(1)) u_all (
        .clk(clk), .rstn(rstn), .i_drive(drive), .i_valid(valid),
        .o_fire(fire_o[0]), .o_driveNext(drv_o[0]), .i_freeNext(free),
        .o_free(free_o[0]), .o_busy(busy_o[0]), .o_err(err_o[0]), .o_state(st_o[0]));

    cselector_n_sync #(.N(N), .DRIVE_DELAY(8), .JOIN_ALL(0)) u_any (
        .clk(clk), .rstn(rstn), .i_drive(drive), .i_valid(valid),
        .o_fire(fire_o[1]), .o_driveNext(drv_o[1]), .i_freeNext(free),
        .o_free(free_o[1]), .o_busy(busy_o[1]), .o_err(err_o[1]), .o_state(st_o[1]));

    cselector_n_sync #(.N(N), .DRIVE_DELAY(0), .JOIN_ALL(1)) u_d0 (
        .clk(clk), .rstn(rstn), .i_drive(drive), .i_valid(valid),
        .o_fire(fire_o[2]), .o_driveNext(drv_o[2]), .i_freeNext(free),
        .o_free(free_o[2]), .o_busy(busy_o[2]), .o_err(err_o[2]), .o_state(st_o[2]));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < NI; i++) begin
            act[i]    = 1'b0;
            acc[i]    = 0;
            m_mask[i] = '0;
            m_pend[i] = '0;
            e_fire[i] = 1'b0;
            e_free[i] = 1'b0;
            e_busy[i] = 1'b0;
            e_err[i]  = 1'b0;
            e_drv[i]  = '0;
        end
    endtask

    // Transaction c accepted at cycle acc: drive pulse lands at acc+1+delay,
    // joining is live from that cycle on; result appears one cycle after inputs.
    task automatic model_step();
        logic [N-1:0] hit;
        for (int i = 0; i < NI; i++) begin
            e_fire[i] = 1'b0;
            e_free[i] = 1'b0;
            e_err[i]  = 1'b0;
            e_drv[i]  = '0;
            if (act[i]) begin
                if (drive) e_err[i] = 1'b1;
                if (m_delay[i] > 0 && cyc == acc[i] + m_delay[i]) e_drv[i] = m_mask[i];
                if (cyc >= acc[i] + 1 + m_delay[i]) begin
                    hit       = free & m_mask[i];
                    m_pend[i] = m_pend[i] & ~hit;
                    if (m_mask[i] == '0 || (m_all[i] ? (m_pend[i] == '0) : (hit != '0))) begin
                        e_free[i] = 1'b1;
                        act[i]    = 1'b0;
                    end
                end
            end else if (drive) begin
                act[i]    = 1'b1;
                acc[i]    = cyc;
                m_mask[i] = valid;
                m_pend[i] = valid;
                e_fire[i] = 1'b1;
                if (m_delay[i] == 0) e_drv[i] = valid;
            end
            e_busy[i] = act[i];
        end
        cyc++;
    endtask

    task automatic compare_all();
        for (int i = 0; i < NI; i++) begin
            check($sformatf("fire%0d", i), 32'(fire_o[i]), 32'(e_fire[i]));
            check($sformatf("drive%0d", i), 32'(drv_o[i]), 32'(e_drv[i]));
            check($sformatf("free%0d", i), 32'(free_o[i]), 32'(e_free[i]));
            check($sformatf("busy%0d", i), 32'(busy_o[i]), 32'(e_busy[i]));
            check($sformatf("err%0d", i), 32'(err_o[i]), 32'(e_err[i]));
            check($sformatf("idle%0d", i), 32'(st_o[i] == ST_IDLE), 32'(!e_busy[i]));
        end
    endtask

    // Called at a negedge: apply inputs for one cycle, then check its results.
    task automatic step(input logic d, input logic [N-1:0] v, input logic [N-1:0] f);
        drive = d;
        valid = v;
        free  = f;
        @(posedge clk);
        if (rstn) model_step();
        @(negedge clk);
        compare_all();
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(1'b0, '0, '0);
    endtask

    task automatic pulse_reset(input int hold);
        drive = 1'b0;
        valid = '0;
        free  = '0;
        rstn  = 1'b0;
        model_clear();
        #1;
        compare_all();
        for (int k = 0; k < hold; k++) begin
            @(posedge clk);
            @(negedge clk);
            compare_all();
        end
        rstn = 1'b1;
    endtask

    initial begin
        model_clear();
        repeat (2) @(posedge clk);
        @(negedge clk);
        compare_all();
        rstn = 1'b1;
        idle(2);

        // selected pair, join on both frees
        step(1'b1, 6'b000101, '0);
        idle(11);
        step(1'b0, '0, 6'b000001);
        idle(2);
        step(1'b0, '0, 6'b000100);
        idle(4);

        // first-free join with a late second free
        step(1'b1, 6'b110000, '0);
        idle(10);
        step(1'b0, '0, 6'b100000);
        idle(1);
        step(1'b0, '0, 6'b010000);
        idle(4);

        // empty mask
        step(1'b1, 6'b000000, '0);
        idle(12);

        // drive while busy
        step(1'b1, 6'b000011, '0);
        idle(4);
        step(1'b1, 6'b111111, '0);
        idle(6);
        step(1'b0, '0, 6'b000011);
        idle(4);

        // unselected and duplicate frees
        step(1'b1, 6'b000011, '0);
        idle(9);
        step(1'b0, '0, 6'b001000);
        step(1'b0, '0, 6'b000001);
        step(1'b0, '0, 6'b000001);
        idle(2);
        step(1'b0, '0, 6'b000010);
        idle(4);

        // drive in the completing cycle
        step(1'b1, 6'b000001, '0);
        idle(8);
        step(1'b1, 6'b000001, 6'b000001);
        idle(4);

        // reset in the middle of a join
        step(1'b1, 6'b000011, '0);
        idle(11);
        pulse_reset(3);
        idle(2);
        step(1'b1, 6'b000001, '0);
        idle(3);
        step(1'b0, '0, 6'b000001);
        idle(12);

        // random traffic
        for (int k = 0; k < 600; k++) begin
            step($urandom_range(0, 5) == 0, N'($urandom), N'($urandom & $urandom));
            if (k == 300) pulse_reset(2);
        end
        idle(20);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
